stream_dmux: RTL
================

Name: stream_dmux

Overview:
- Parametrised, registered 1-to-N demultiplexer with valid/ready handshaking on the input and on every output channel.
- Each input word is steered to the channel named by S, or to all channels when broadcast is set.
- Every channel owns a one-entry output register, so each channel drains independently at full throughput.
- Sits between a single producer and N independent consumers; it is the streaming successor to the combinational 4-way dmux.

Parameters:
- N_CH, 4, number of output channels (>=2; need not be a power of 2).
- DATA_W, 8, data word width in bits.
- SEL_W, $clog2(N_CH), select width (derived localparam, not overridable).
- CNT_W, 8, width of the drop counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- Enable  input  1  global accept gate; 0 blocks new input, outputs keep draining.
- Bcast  input  1  1 = copy the word to all channels; S is ignored.
- S  input  SEL_W  destination channel index; sampled with Data_in.
- Data_in  input  DATA_W  input word.
- In_valid  input  1  producer has a word.
- In_ready  output  1  block accepts the word this cycle.
- O_data  output  N_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W].
- O_valid  output  N_CH  per-channel word present.
- O_ready  input  N_CH  per-channel consumer accepts.
- Drop_cnt  output  CNT_W  saturating count of words dropped for out-of-range S.

Behaviour:
- Reset: on the clk edge with rst=1, O_valid=0, O_data=0 and Drop_cnt=0. rst overrides any transfer in the same cycle; in-flight words are discarded. In_ready may be high during rst; any transfer during rst is lost.
- Channel free: can_acc[c] = !O_valid[c] || O_ready[c]. A pop and a push on the same channel in the same cycle are allowed.
- In_ready is combinational from Enable, Bcast, S and O_ready (no dependency on In_valid):
  - Enable=0: 0.
  - Bcast=1: AND of can_acc over all channels.
  - Bcast=0, S<N_CH: can_acc[S].
  - Bcast=0, S>=N_CH: 1 (the word is sunk).
- Transfer: In_valid && In_ready at a clk edge.
  - Unicast: O_data[S] <= Data_in and O_valid[S] <= 1.
  - Broadcast: every channel loads Data_in and sets O_valid.
  - Out-of-range S: no channel is written; Drop_cnt increments, saturating at 2^CNT_W-1 with no wrap.
- Latency: a word appears on O_valid/O_data 1 cycle after acceptance.
  - Throughput: 1 word/cycle per channel when O_ready is held high.
- Pop: O_valid[c] && O_ready[c] with no push to c clears O_valid[c]. With a simultaneous push, O_valid[c] stays 1 and O_data[c] takes the new word.
- Hold: while O_valid[c] && !O_ready[c], O_data[c] is stable and is not overwritten.
  - A unicast to c is back-pressured (In_ready=0).
  - A broadcast is back-pressured if any channel is stalled: all-or-nothing, never a partial broadcast.
- O_data[c] keeps its last value when O_valid[c]=0; consumers ignore it.
- Enable falling mid-stream: no new accepts; already-registered words remain and drain normally.
- S and Bcast are don't-care when In_valid=0. Drop_cnt changes only on an accepted out-of-range transfer.
- No combinational path from In_valid to O_valid; all outputs except In_ready are registered.

Test Plan:
- Reset then unicast. Set rst=1 for 2 cycles, then Enable=1, O_ready=4'b1111. Send words 0xA0..0xA3 with S=0..3 on consecutive cycles. Required: each word appears on the matching channel exactly 1 cycle after acceptance, In_ready is held at 1, and O_valid is one-hot per cycle.
- Back-pressure. Set O_ready[2]=0 and send 0x55 then 0x66 to S=2. Required: O_valid[2]=1 with O_data[2]=0x55 held, and In_ready=0 for the 0x66 word. Raise O_ready[2] for 1 cycle: 0x55 pops and 0x66 loads in the same edge, so O_valid[2] stays 1 with O_data[2]=0x66.
- Broadcast all-or-nothing. Fill channel 1 with O_ready[1]=0, then send 0x3C with Bcast=1. Required: In_ready=0 and no channel changes. Release O_ready[1]: 0x3C is accepted and all 4 O_valid go high with 0x3C on each channel.
- Out-of-range drop. Use N_CH=3, CNT_W=2 and send 5 words with S=3. Required: In_ready=1 throughout, O_valid stays 0, and Drop_cnt reads 1, 2, 3, 3, 3 (saturates).
- Enable gating. Hold In_valid=1 and Enable=0 for 4 cycles with previously loaded words present. Required: In_ready=0, nothing is accepted, and loaded words drain as O_ready asserts.
- Reset mid-operation. Assert rst while O_valid=4'b1011 and an input transfer is offered. Required: next cycle O_valid=0, Drop_cnt=0, and the offered word does not appear.

Source files
------------

// File: rtl/stream_dmux.sv
// Registered 1-to-N stream demultiplexer with per-channel one-entry output
// registers, all-or-nothing broadcast and a saturating drop counter.
module stream_dmux #(
   parameter  int N_CH   = 4,
   parameter  int DATA_W = 8,
   parameter  int CNT_W  = 8,
   localparam int SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   Enable,
   input  logic                   Bcast,
   input  logic [SEL_W-1:0]       S,
   input  logic [DATA_W-1:0]      Data_in,
   input  logic                   In_valid,
   output logic                   In_ready,
   output logic [N_CH*DATA_W-1:0] O_data,
   output logic [N_CH-1:0]        O_valid,
   input  logic [N_CH-1:0]        O_ready,
   output logic [CNT_W-1:0]       Drop_cnt
);

   localparam logic [SEL_W:0] N_CH_EXT = (SEL_W + 1)'(N_CH);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : CNT_W'(v + 1'b1);
   endfunction

   logic [DATA_W-1:0] r_data_p1 [N_CH];
   logic [N_CH-1:0]   r_vld_p1;
   logic [CNT_W-1:0]  r_drop_cnt;

   logic [N_CH-1:0]   w_can_acc;
   logic [N_CH-1:0]   w_sel_onehot;
   logic [N_CH-1:0]   w_push;
   logic              w_in_range;
   logic              w_all_free;
   logic              w_sel_free;
   logic              w_fire;
   logic              w_drop;

   // p0: acceptance decision, combinational from Enable/Bcast/S/O_ready only
   always_comb begin
      w_can_acc    = '0;
      w_sel_onehot = '0;
      for (int c = 0; c < N_CH; c++) begin
         w_can_acc[c]    = !r_vld_p1[c] || O_ready[c];
         w_sel_onehot[c] = (S == SEL_W'(c));
      end
      w_in_range = ({1'b0, S} < N_CH_EXT);
      w_all_free = &w_can_acc;
      w_sel_free = |(w_can_acc & w_sel_onehot);
      In_ready   = 1'b0;
      if (Enable) begin
         if (Bcast)           In_ready = w_all_free;
         else if (w_in_range) In_ready = w_sel_free;
         else                 In_ready = 1'b1;
      end
      w_fire = In_valid && In_ready;
      w_drop = w_fire && !Bcast && !w_in_range;
      w_push = '0;
      for (int c = 0; c < N_CH; c++)
         w_push[c] = w_fire && (Bcast || w_sel_onehot[c]);
   end

   // p1: per-channel output registers; a push wins over a simultaneous pop
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld_p1   <= '0;
         r_drop_cnt <= '0;
         for (int c = 0; c < N_CH; c++)
            r_data_p1[c] <= '0;
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            if (w_push[c]) begin
               r_data_p1[c] <= Data_in;
               r_vld_p1[c]  <= 1'b1;
            end else if (O_ready[c]) begin
               r_vld_p1[c]  <= 1'b0;
            end
         end
         if (w_drop)
            r_drop_cnt <= sat_inc(r_drop_cnt);
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_out
      assign O_data[g*DATA_W +: DATA_W] = r_data_p1[g];
   end

   assign O_valid  = r_vld_p1;
   assign Drop_cnt = r_drop_cnt;

endmodule
